// File: rtl/ahb2_sram_slv.sv
// ahb2_sram_slv
//
// AHB2 slave backed by a word-addressed on-chip array. Each accepted
// NONSEQ/SEQ transfer is held for WAIT_CYCLES wait states before its final
// data cycle. Out-of-range, oversized or misaligned transfers get the
// two-cycle ERROR response and never touch the array.
//
// Ports
//   hclk       bus clock
//   hreset     synchronous active-high reset (array contents are kept)
//   hsel       slave select
//   haddr      byte address (address phase)
//   htrans     IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//   hwrite     1 = write
//   hsize      0 = byte, 1 = half, 2 = word
//   hburst     burst type, ignored (every beat is handled on its own)
//   hprot      protection, ignored
//   hwdata     write data (data phase)
//   hready_in  bus-level hready; the address phase is only sampled when high
//   hreadyout  slave ready
//   hresp      OKAY=00 / ERROR=01
//   hrdata     read data, zero outside the final data cycle of a read
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer in its data phase; accept point
// ST_WAIT  | wait states, hreadyout low, down-counter running
// ST_DATA  | final data cycle; read data out / write commits; accept point
// ST_ERR1  | first ERROR cycle, hreadyout low
// ST_ERR2  | second ERROR cycle, hreadyout high; accept point
module ahb2_sram_slv #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [3:0]            hprot,
   input  logic [DATA_WIDTH-1:0] hwdata,
   input  logic                  hready_in,
   output logic                  hreadyout,
   output logic [1:0]            hresp,
   output logic [DATA_WIDTH-1:0] hrdata
);

   localparam int         IDX_W     = $clog2(MEM_DEPTH);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_ERR  = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [IDX_W-1:0]      idx_q;
   logic [1:0]            lane_q;
   logic                  write_q;
   logic [2:0]            size_q;
   logic [3:0]            wait_cnt_q;
   logic [3:0]            byte_en;
   logic                  accept;
   logic                  addr_err;
   logic                  size_err;
   logic                  align_err;
   logic                  xfer_err;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic unused_ok;
   assign unused_ok = ^{htrans[0], hburst, hprot};

   // Gating with our own hreadyout keeps the address bus unsampled while we
   // stall, even if hready_in is not wired back from the bus correctly.
   assign accept    = hsel & htrans[1] & hready_in & hreadyout;
   assign addr_err  = |haddr[ADDR_WIDTH-1:IDX_W+2];
   assign size_err  = (hsize > 3'd2);
   assign align_err = ((hsize == 3'd1) && haddr[0]) ||
                      ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
   assign xfer_err  = addr_err | size_err | align_err;

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         lane_q     <= 2'b00;
         write_q    <= 1'b0;
         size_q     <= 3'd0;
         wait_cnt_q <= 4'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            idx_q   <= haddr[IDX_W+1:2];
            lane_q  <= haddr[1:0];
            write_q <= hwrite;
            size_q  <= hsize;
         end
         if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
            wait_cnt_q <= WAIT_LOAD;
         end else if (state_q == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT: begin
            if (wait_cnt_q == 4'd0) state_d = ST_DATA;
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
         default: begin
            // IDLE, DATA and ERR2 all end on an accept point
            state_d = ST_IDLE;
            if (accept) begin
               if (xfer_err)             state_d = ST_ERR1;
               else if (WAIT_CYCLES > 0) state_d = ST_WAIT;
               else                      state_d = ST_DATA;
            end
         end
      endcase
   end

   always_comb begin
      hreadyout = 1'b1;
      hresp     = RESP_OKAY;
      hrdata    = '0;
      case (state_q)
         ST_WAIT: hreadyout = 1'b0;
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = RESP_ERR;
         end
         ST_ERR2: hresp = RESP_ERR;
         ST_DATA: begin
            // straight from the array so a write committed last edge is seen
            if (!write_q) hrdata = mem[idx_q];
         end
         default: hreadyout = 1'b1;
      endcase
   end

   always_comb begin
      byte_en = 4'b0000;
      case (size_q)
         3'd0:    byte_en = 4'b0001 << lane_q;
         3'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!hreset && (state_q == ST_DATA) && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
         end
      end
   end

endmodule
